alu_cmd_issuer: RTL
===================

# alu_cmd_issuer

Command-side initiator for the accumulator ALU. It accepts encoded commands (opcode plus operand) on a valid/ready port and replays each one as the ALU's single-cycle one-hot strobe set, including `in`. It then captures the ALU's registered result and returns it on a valid/ready response port. It sits between a host or sequencer and one `ALU` instance, and it owns that ALU's `rst`, `on` and `off` lines.

## Interface
- `n`, default 8: data width. Must match the ALU's `n`.
- `clk` input 1: single clock, shared with the ALU.
- `rst` input 1: asynchronous, active-low reset (asserted when 0).
- `cmd_valid` input 1: a command is present.
- `cmd_ready` output 1: the issuer accepts a command on this edge.
- `cmd_op` input 4: opcode.
- `cmd_data` input n: operand.
- `rsp_valid` output 1: a response is held.
- `rsp_ready` input 1: the consumer takes the response.
- `rsp_data` output n: captured ALU result.
- `rsp_err` output 1: the opcode was illegal; no ALU activity took place.
- `rsp_pwr` output 1: shadow ALU power state at capture time.
- `alu_in` output n: ALU operand.
- `alu_rst`, `alu_on`, `alu_off` output 1 each: ALU control strobes.
- `alu_add`, `alu_sub`, `alu_mult`, `alu_andd`, `alu_orr`, `alu_xorr`, `alu_nott`, `alu_load` output 1 each: ALU operation strobes.
- `alu_out` input n: ALU result output.

## Operation
- Opcodes:
  - 0 LOAD, 1 ADD, 2 SUB, 3 MULT, 4 AND, 5 OR, 6 XOR, 7 NOT.
  - 8 CLEAR drives `alu_rst`.
  - 9 ON and 10 OFF drive `alu_on` / `alu_off`.
  - 11–15 are illegal.
- Per command, at most one strobe is high, for exactly one cycle. All other strobes are 0. This avoids dependence on the ALU's priority ordering.
- `alu_in` = latched `cmd_data` during ISSUE, and 0 otherwise.
- FSM states: INIT, IDLE, ISSUE, CAPTURE, RESP.
  - INIT: first cycle after reset release. `alu_rst`=1 and `cmd_ready`=0. Next state IDLE. Shadow power is set to 1, because ALU `rst` forces power on and clears the result.
  - IDLE: `cmd_ready`=1. When `cmd_valid` is high, latch op/data. Legal op goes to ISSUE. Illegal op goes directly to RESP with `rsp_err`=1 and `rsp_data`=0.
  - ISSUE: the decoded strobe is high. Shadow power updates on this edge: ON or CLEAR sets it to 1, OFF sets it to 0.
  - CAPTURE: all strobes are 0, so the ALU outputs its held register. Register `rsp_data`←`alu_out`, `rsp_pwr`←shadow, `rsp_err`←0. Next state RESP.
  - RESP: `rsp_valid`=1. Data and flags are stable until the cycle after `rsp_valid & rsp_ready`, which returns to IDLE.
- Operations issued while shadow power is 0 still run the full sequence. The ALU holds its value, so `rsp_data` returns the unchanged accumulator with `rsp_pwr`=0.
- Arithmetic follows the ALU: n-bit, wrap-around, product truncated to the low n bits. The issuer never alters the result.

## Timing
- While `rst`=0: every output is 0, the state is INIT, shadow power is 0, and response registers are 0.
- Legal command accepted at edge E0:
  - Strobe high during E0→E1; the ALU registers at E1.
  - `rsp_valid` rises after E2.
  - `cmd_ready` returns one cycle after the response handshake.
- Minimum legal-command period is 4 cycles when `rsp_ready` is held high.
- Illegal command: `rsp_valid` rises one edge after acceptance.
- `cmd_ready` is 0 in every state except IDLE. No command is accepted in the same cycle as a response handshake.
- Reset asserted mid-command:
  - All strobes drop immediately and asynchronously.
  - The in-flight command and any held response are discarded.
  - INIT re-runs after release.
- `rsp_valid` never deasserts without a handshake.

## Structure
- Shared include `alu_defs.vh` holds:
  - opcode constants `OP_LOAD`..`OP_OFF`;
  - `OP_W`=4;
  - the state encodings.
- One combinational sub-module `alu_op_decode`: 4-bit op in, 11-bit one-hot strobe vector plus `illegal` out.
- The FSM, operand/response registers and shadow power stay in `alu_cmd_issuer`.

## Test plan
- Reset release: `alu_rst` is high for exactly 1 cycle, then `cmd_ready`=1. CLEAR then LOAD 0x00 → `rsp_data`=0x00, `rsp_pwr`=1.
- LOAD 0x05, ADD 0x03, SUB 0x01, MULT 0x04 → responses 0x05, 0x08, 0x07, 0x1C. Exactly one strobe per command, each 1 cycle wide.
- LOAD 0xC0, MULT 0x04 → 0x00 (truncation). LOAD 0x0F, NOT → 0xF0. XOR 0xFF → 0x0F.
- OFF, ADD 0x10 → response 0x0F with `rsp_pwr`=0. ON, ADD 0x10 → 0x1F with `rsp_pwr`=1.
- Opcode 0xC → `rsp_err`=1 with no strobe ever high. Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0.
- Pull `rst` low during ISSUE of ADD 0x01 → strobes 0 in the same cycle. After release, INIT runs and the next LOAD 0x2A → 0x2A.

Source files
------------

// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the accumulator-ALU command issuer: opcodes, strobe
// vector layout and FSM state encoding.
package alu_cmd_issuer_pkg;

  localparam int OP_W    = 4;
  localparam int NUM_STB = 11;

  // Opcode value doubles as the bit index of its strobe in the one-hot vector
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd7;
  localparam logic [OP_W-1:0] OP_CLEAR = 4'd8;
  localparam logic [OP_W-1:0] OP_ON    = 4'd9;
  localparam logic [OP_W-1:0] OP_OFF   = 4'd10;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_OFF;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_op_decode.sv
// Combinational opcode decoder: one-hot strobe vector indexed by opcode, plus
// an illegal flag for the unused opcode space.
module alu_op_decode
  import alu_cmd_issuer_pkg::*;
(
  input  logic [OP_W-1:0]    op_i,
  output logic [NUM_STB-1:0] stb_o,
  output logic               illegal_o
);

  always_comb begin
    stb_o     = '0;
    illegal_o = !op_is_legal(op_i);
    for (int i = 0; i < NUM_STB; i++) begin
      stb_o[i] = (op_i == OP_W'(i));
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Replays valid/ready commands as single-cycle one-hot ALU strobes, then
// captures the ALU's registered result onto a valid/ready response port.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int n = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [n-1:0]    cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [n-1:0]    rsp_data,
  output logic            rsp_err,
  output logic            rsp_pwr,
  output logic [n-1:0]    alu_in,
  output logic            alu_rst,
  output logic            alu_on,
  output logic            alu_off,
  output logic            alu_add,
  output logic            alu_sub,
  output logic            alu_mult,
  output logic            alu_andd,
  output logic            alu_orr,
  output logic            alu_xorr,
  output logic            alu_nott,
  output logic            alu_load,
  input  logic [n-1:0]    alu_out
);

  state_e               state_q, state_d;
  logic [NUM_STB-1:0]   stb_dec;
  logic                 illegal;
  logic [NUM_STB-1:0]   stb_q;
  logic [n-1:0]         data_q;
  logic                 pwr_q;
  logic [n-1:0]         rsp_data_q;
  logic                 rsp_err_q;
  logic                 rsp_pwr_q;
  logic [NUM_STB-1:0]   stb_out;

  // The command is decoded at acceptance, so only the one-hot vector is held
  alu_op_decode u_dec (
    .op_i      (cmd_op),
    .stb_o     (stb_dec),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_q      <= '0;
      data_q     <= '0;
      pwr_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_pwr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: pwr_q <= 1'b1;
        ST_IDLE: begin
          if (cmd_valid) begin
            stb_q  <= stb_dec;
            data_q <= cmd_data;
            if (illegal) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
              rsp_pwr_q  <= pwr_q;
            end
          end
        end
        ST_ISSUE: begin
          // Shadow of the ALU's power latch, which rst also forces on
          if (stb_q[OP_ON] || stb_q[OP_CLEAR]) pwr_q <= 1'b1;
          else if (stb_q[OP_OFF])               pwr_q <= 1'b0;
        end
        ST_CAPTURE: begin
          rsp_data_q <= alu_out;
          rsp_pwr_q  <= pwr_q;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    state_d = ST_IDLE;
      ST_IDLE:    if (cmd_valid) state_d = illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  // INIT is the reset state, so its rst strobe is gated to stay low in reset
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    stb_out   = (state_q == ST_ISSUE) ? stb_q : '0;
    alu_in    = (state_q == ST_ISSUE) ? data_q : '0;
    alu_rst   = stb_out[OP_CLEAR] | ((state_q == ST_INIT) & rst);
    alu_on    = stb_out[OP_ON];
    alu_off   = stb_out[OP_OFF];
    alu_load  = stb_out[OP_LOAD];
    alu_add   = stb_out[OP_ADD];
    alu_sub   = stb_out[OP_SUB];
    alu_mult  = stb_out[OP_MULT];
    alu_andd  = stb_out[OP_AND];
    alu_orr   = stb_out[OP_OR];
    alu_xorr  = stb_out[OP_XOR];
    alu_nott  = stb_out[OP_NOT];
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
    rsp_pwr   = rsp_pwr_q;
  end

endmodule
